// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG sampler controller.
//  - trng_state_t : controller state encoding
//  - DEF_*        : default parameter values
//  - vn_decode()  : von Neumann pair decoder
package trng_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    COLLECT,
    PRESENT,
    FAIL
  } trng_state_t;

  localparam int unsigned DEF_WORD_W        = 32;
  localparam int unsigned DEF_SAMPLE_DIV    = 8;
  localparam int unsigned DEF_WARMUP_CYCLES = 64;
  localparam int unsigned DEF_RCT_LIMIT     = 16;

  typedef struct packed {
    logic emit;     // pair is 01 or 10
    logic bit_val;  // debiased bit when emit=1
  } vn_out_t;

  // 10 -> 1, 01 -> 0, 00/11 -> no output. The emitted bit equals the first sample.
  function automatic vn_out_t vn_decode(input logic first, input logic second);
    vn_out_t r;
    r.emit    = first ^ second;
    r.bit_val = first;
    return r;
  endfunction

endpackage

// File: rtl/trng_sync2.sv
// Two-flop synchronizer for the asynchronous oscillator output.
// Ports:
//  CLK   in  system clock
//  RESET in  synchronous active-high reset, clears both flops to 0
//  d     in  asynchronous input
//  q     out synchronized output (two CLK cycles of latency)
module trng_sync2 (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/trng_sampler_ctrl.sv
// Ring-oscillator entropy source sequencer. Keeps the oscillator parked while
// idle, releases it, waits out warm-up, samples the synchronized raw bit every
// SAMPLE_DIV cycles, von Neumann debiases the samples and packs the result into
// WORD_W-bit words offered on a valid/ready port.
// Optional feature macro: TRNG_HEALTH_EN adds a repetition-count health test
// with a sticky FAIL state left only through RESET.
// Ports:
//  CLK            in   system clock
//  RESET          in   synchronous active-high reset
//  START          in   level; 1 = produce words, 0 = stop and park oscillator
//  RAW_ENTROPY_IN in   asynchronous raw oscillator bit
//  RO_RESET       out  oscillator reset, 1 = oscillator stopped
//  RAND_DATA      out  random word, stable while RAND_VALID=1
//  RAND_VALID     out  word available
//  RAND_READY     in   consumer accepts the word
//  BUSY           out  controller not in IDLE
//  HEALTH_FAIL    out  sticky health-test failure
module trng_sampler_ctrl
  import trng_pkg::*;
#(
  parameter int unsigned WORD_W        = DEF_WORD_W,
  parameter int unsigned SAMPLE_DIV    = DEF_SAMPLE_DIV,
  parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int unsigned RCT_LIMIT     = DEF_RCT_LIMIT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              RAW_ENTROPY_IN,
  output logic              RO_RESET,
  output logic [WORD_W-1:0] RAND_DATA,
  output logic              RAND_VALID,
  input  logic              RAND_READY,
  output logic              BUSY,
  output logic              HEALTH_FAIL
);

  localparam int unsigned WARM_W = $clog2(WARMUP_CYCLES + 1);
  localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
  localparam int unsigned BIT_W  = $clog2(WORD_W + 1);

  trng_state_t       state, next_state;
  logic [WARM_W-1:0] warm_cnt;
  logic [DIV_W-1:0]  samp_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] word;
  logic              have_first;  // first sample of the current pair is held
  logic              first_bit;
  logic              raw_sync;
  logic              tick;
  logic              emit;
  logic              word_full;
  vn_out_t           vn;

  trng_sync2 u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (RAW_ENTROPY_IN),
    .q     (raw_sync)
  );

  assign tick      = (state == COLLECT) && (samp_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign vn        = vn_decode(first_bit, raw_sync);
  assign emit      = tick && have_first && vn.emit;
  // The word is handed over the cycle after its last bit lands in the shifter.
  assign word_full = (bit_cnt == BIT_W'(WORD_W));

`ifdef TRNG_HEALTH_EN
  localparam int unsigned RCT_W = $clog2(RCT_LIMIT + 1);

  logic [RCT_W-1:0] run_cnt, run_next;
  logic             last_sample;
  logic             rct_trip;

  // run_cnt == 0 means no sample seen since the last WARMUP entry.
  always_comb begin
    run_next = run_cnt;
    if (tick) begin
      if ((run_cnt != '0) && (raw_sync == last_sample)) run_next = run_cnt + 1'b1;
      else                                              run_next = RCT_W'(1);
    end
  end

  assign rct_trip = tick && (run_next == RCT_W'(RCT_LIMIT));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      run_cnt     <= '0;
      last_sample <= 1'b0;
    end else if ((state == IDLE) && (next_state == WARMUP)) begin
      run_cnt     <= '0;
    end else if (tick) begin
      run_cnt     <= run_next;
      last_sample <= raw_sync;
    end
  end

  assign HEALTH_FAIL = (state == FAIL);
`else
  assign HEALTH_FAIL = 1'b0;
`endif

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (START) next_state = WARMUP;
      WARMUP: begin
        if (!START)                                        next_state = IDLE;
        else if (warm_cnt == WARM_W'(WARMUP_CYCLES - 1))   next_state = COLLECT;
      end
      COLLECT: begin
`ifdef TRNG_HEALTH_EN
        // A failing source wins over a stop request so the failure is never missed.
        if (rct_trip)        next_state = FAIL;
        else
`endif
        if (!START)          next_state = IDLE;
        else if (word_full)  next_state = PRESENT;
      end
      PRESENT: if (RAND_READY) next_state = START ? COLLECT : IDLE;
`ifdef TRNG_HEALTH_EN
      FAIL:    next_state = FAIL;
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      warm_cnt   <= '0;
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      word       <= '0;
      have_first <= 1'b0;
      first_bit  <= 1'b0;
      RAND_DATA  <= '0;
    end else begin
      state <= next_state;

      warm_cnt <= (state == WARMUP) ? warm_cnt + 1'b1 : '0;

      // Sampling runs only while staying in COLLECT; any exit restarts the divider.
      if ((state == COLLECT) && (next_state == COLLECT))
        samp_cnt <= tick ? '0 : samp_cnt + 1'b1;
      else
        samp_cnt <= '0;

      if (state != COLLECT) begin
        have_first <= 1'b0;
        bit_cnt    <= '0;
      end else begin
        if (tick) begin
          have_first <= ~have_first;
          first_bit  <= raw_sync;
        end
        if (word_full) begin
          bit_cnt <= '0;
        end else if (emit) begin
          word    <= {word[WORD_W-2:0], vn.bit_val};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if ((state == COLLECT) && (next_state == PRESENT)) RAND_DATA <= word;
    end
  end

  assign RO_RESET   = (state == IDLE) || (state == FAIL);
  assign RAND_VALID = (state == PRESENT);
  assign BUSY       = (state != IDLE);

endmodule

// File: tb/tb_trng_sampler_ctrl.sv
// Directed bench for trng_sampler_ctrl with WORD_W=8, SAMPLE_DIV=4,
// WARMUP_CYCLES=16, RCT_LIMIT=6. Inputs change and outputs are sampled 1 ns
// after the rising edge. Raw samples are placed right after the edge that
// starts each 4-cycle sample period so the synchronizer has settled by the tick.
module tb_trng_sampler_ctrl;

  localparam int W    = 8;
  localparam int SDIV = 4;
  localparam int WARM = 16;

  logic         CLK = 1'b0;
  logic         RESET, START, RAW_ENTROPY_IN, RAND_READY;
  logic         RO_RESET, RAND_VALID, BUSY, HEALTH_FAIL;
  logic [W-1:0] RAND_DATA;

  int n_tests = 0;
  int n_fail  = 0;

  trng_sampler_ctrl #(
    .WORD_W        (W),
    .SAMPLE_DIV    (SDIV),
    .WARMUP_CYCLES (WARM),
    .RCT_LIMIT     (6)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .START          (START),
    .RAW_ENTROPY_IN (RAW_ENTROPY_IN),
    .RO_RESET       (RO_RESET),
    .RAND_DATA      (RAND_DATA),
    .RAND_VALID     (RAND_VALID),
    .RAND_READY     (RAND_READY),
    .BUSY           (BUSY),
    .HEALTH_FAIL    (HEALTH_FAIL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] samples;  // raw samples, oldest in bit n-1
    int          n;
    int          hold;     // cycles READY stays low while the word is offered
    bit          stop;     // drop START while the word is offered
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_samples(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      RAW_ENTROPY_IN = s[n-1-i];
      step(SDIV);
    end
  endtask

  initial begin
    vecs[0] = '{32'h9A59, 16, 0, 1'b0, 8'hB2};  // 10,01,10,10,01,01,10,01
    vecs[1] = '{32'b11010010011110100001011110, 26, 10, 1'b0, 8'h59};  // 00/11 interleaved
    vecs[2] = '{32'hAA55, 16, 2, 1'b0, 8'hF0};
    vecs[3] = '{32'h5555, 16, 0, 1'b0, 8'h00};
    vecs[4] = '{32'hAAAA, 16, 3, 1'b1, 8'hFF};

    RESET = 1'b1; START = 1'b0; RAW_ENTROPY_IN = 1'b0; RAND_READY = 1'b0;
    step(2);
    check("rst_ro_reset", RO_RESET, 1);
    check("rst_valid", RAND_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_data", RAND_DATA, 8'h00);
    check("rst_health", HEALTH_FAIL, 0);
    RESET = 1'b0;
    step(1);

    // Continuous generation: warm-up once, then back-to-back words.
    START = 1'b1;
    step(1);
    check("start_ro_release", RO_RESET, 0);
    check("start_busy", BUSY, 1);
    step(WARM);
    foreach (vecs[v]) begin
      RAND_READY = (vecs[v].hold == 0);
      drive_samples(vecs[v].samples, vecs[v].n);
      check($sformatf("v%0d_pre_valid", v), RAND_VALID, 0);
      step(1);
      check($sformatf("v%0d_valid", v), RAND_VALID, 1);
      check($sformatf("v%0d_data", v), RAND_DATA, vecs[v].exp_data);
      if (vecs[v].stop) START = 1'b0;
      for (int h = 0; h < vecs[v].hold; h++) begin
        step(1);
        check($sformatf("v%0d_hold_valid", v), RAND_VALID, 1);
        check($sformatf("v%0d_hold_data", v), RAND_DATA, vecs[v].exp_data);
      end
      RAND_READY = 1'b1;
      step(1);
      check($sformatf("v%0d_valid_drop", v), RAND_VALID, 0);
      if (vecs[v].stop) begin
        check($sformatf("v%0d_idle_busy", v), BUSY, 0);
        check($sformatf("v%0d_idle_ro", v), RO_RESET, 1);
      end
    end

    // Stop after 3 emitted bits, then restart and expect a whole fresh word.
    RAND_READY = 1'b0;
    START = 1'b1;
    step(1 + WARM);
    drive_samples(32'h2A, 6);
    START = 1'b0;
    step(1);
    check("abort_busy", BUSY, 0);
    check("abort_ro", RO_RESET, 1);
    START = 1'b1;
    step(1 + WARM);
    drive_samples(32'h5AA5, 16);
    check("restart_pre_valid", RAND_VALID, 0);
    step(1);
    check("restart_valid", RAND_VALID, 1);
    check("restart_data", RAND_DATA, 8'h3C);
    START = 1'b0;
    step(3);
    check("stop_in_present_valid", RAND_VALID, 1);
    check("stop_in_present_data", RAND_DATA, 8'h3C);

    // Reset while a word is offered.
    RESET = 1'b1;
    step(1);
    check("rst_present_valid", RAND_VALID, 0);
    check("rst_present_busy", BUSY, 0);
    check("rst_present_ro", RO_RESET, 1);
    check("rst_present_data", RAND_DATA, 8'h00);
    RESET = 1'b0;
    step(1);

    // Raw bit stuck at 1.
    RAW_ENTROPY_IN = 1'b1;
    START = 1'b1;
    step(1 + WARM);
    step(5 * SDIV);
    check("stuck_5th_health", HEALTH_FAIL, 0);
    step(SDIV);
`ifdef TRNG_HEALTH_EN
    check("stuck_6th_health", HEALTH_FAIL, 1);
    check("stuck_6th_ro", RO_RESET, 1);
    check("stuck_6th_busy", BUSY, 1);
    check("stuck_6th_valid", RAND_VALID, 0);
    START = 1'b0;
    step(3);
    check("fail_start0_health", HEALTH_FAIL, 1);
    check("fail_start0_busy", BUSY, 1);
    START = 1'b1;
    step(3);
    check("fail_start1_ro", RO_RESET, 1);
    check("fail_start1_health", HEALTH_FAIL, 1);
    RESET = 1'b1;
    step(1);
    check("fail_rst_health", HEALTH_FAIL, 0);
    check("fail_rst_busy", BUSY, 0);
    RESET = 1'b0;
`else
    check("stuck_6th_health", HEALTH_FAIL, 0);
    check("stuck_6th_ro", RO_RESET, 0);
    begin
      logic saw_valid;
      logic saw_health;
      saw_valid  = 1'b0;
      saw_health = 1'b0;
      for (int i = 0; i < 120; i++) begin
        step(1);
        saw_valid  = saw_valid | RAND_VALID;
        saw_health = saw_health | HEALTH_FAIL;
      end
      check("stuck_no_valid", saw_valid, 0);
      check("stuck_no_health", saw_health, 0);
    end
    START = 1'b0;
`endif
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
